// File: rtl/button_ctrl_pkg.sv
// ============================================================================
// Module   : button_ctrl_pkg
// Purpose  : Status encodings shared with control_fsm, plus the command bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  typedef struct packed {
    logic reset;
    logic stop;
    logic start;
  } cmd_t;

  // The toggle button means "stop" only while running; an illegal status issues nothing.
  function automatic cmd_t decode_ss(input logic [1:0] status);
    cmd_t cmd;
    cmd = '0;
    case (status)
      ST_RUNNING:        cmd.stop  = 1'b1;
      ST_IDLE, ST_PAUSED: cmd.start = 1'b1;
      default:           cmd       = '0;
    endcase
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_ctrl_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchroniser, stable-sample debouncer and registered rise detect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int                C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         sync_q;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               level_prev_q;
  logic               rise_q;

  // The counter stops at C_CNT_LAST, so it can never wrap.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == C_CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

`default_nettype wire

// File: rtl/button_ctrl.sv
// ============================================================================
// Module   : button_ctrl
// Purpose  : Push-button front-end producing start/stop/reset pulses for control_fsm.
//            Optional macro LONG_PRESS_RESET_EN adds an SS long-press reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       ss_level,
  output logic       rst_level
);

  logic w_ss_level, w_ss_rise;
  logic w_rst_level, w_rst_rise;
  logic w_long_fire;
  cmd_t cmd_q, cmd_d;
  cmd_t w_ss_cmd;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ss_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_ss_raw),
    .level (w_ss_level),
    .rise  (w_ss_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_rst_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_rst_raw),
    .level (w_rst_level),
    .rise  (w_rst_rise)
  );

`ifdef LONG_PRESS_RESET_EN
  localparam int                 C_HOLD_W    = $clog2(LONG_PRESS_CYCLES);
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_FIRE = C_HOLD_W'(LONG_PRESS_CYCLES - 2);

  logic [C_HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (!w_ss_level) begin
      hold_d = '0;
    end else if (hold_q != C_HOLD_LAST) begin
      hold_d = hold_q + C_HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Fires on the step into the saturated value, so only once per press.
  assign w_long_fire = w_ss_level && (hold_q == C_HOLD_FIRE);
`else
  logic [31:0] w_unused_hold_cfg;
  assign w_unused_hold_cfg = LONG_PRESS_CYCLES;
  assign w_long_fire       = 1'b0;
`endif

  assign w_ss_cmd = decode_ss(status);

  // Reset wins over a coincident start/stop.
  always_comb begin
    cmd_d       = '0;
    cmd_d.reset = w_rst_rise | w_long_fire;
    if (w_ss_rise && !cmd_d.reset) begin
      cmd_d.start = w_ss_cmd.start;
      cmd_d.stop  = w_ss_cmd.stop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  assign start     = cmd_q.start;
  assign stop      = cmd_q.stop;
  assign reset     = cmd_q.reset;
  assign ss_level  = w_ss_level;
  assign rst_level = w_rst_level;

endmodule

`default_nettype wire

// File: tb/tb_button_ctrl.sv
// ============================================================================
// Module   : tb_button_ctrl
// Purpose  : Scoreboarded bench for button_ctrl (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_ctrl;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       btn_ss_raw  = 1'b0;
  logic       btn_rst_raw = 1'b0;
  logic [1:0] status      = 2'b00;
  logic       start, stop, reset, ss_level, rst_level;

  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  // Expected pulse {reset,stop,start} at the negedge where cyc == at.
  typedef struct {
    int unsigned at;
    logic [2:0]  p;
  } exp_t;
  exp_t sb[$];

  button_ctrl #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_ss_raw  (btn_ss_raw),
    .btn_rst_raw (btn_rst_raw),
    .status      (status),
    .start       (start),
    .stop        (stop),
    .reset       (reset),
    .ss_level    (ss_level),
    .rst_level   (rst_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    logic [2:0] want;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({start, stop, reset, ss_level, rst_level} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state got=%b want=00000", {start, stop, reset, ss_level, rst_level});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL idle_after_reset cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
  endtask

  task automatic test_press_start();
    logic [2:0] want;
    status     = 2'b00;
    btn_ss_raw = 1'b1;
    sb.push_back('{at: cyc + 8, p: 3'b001});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL press_start cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
    total++;
    if (ss_level !== 1'b1) begin bad++; $display("FAIL ss_level_high got=%b want=1", ss_level); end
    btn_ss_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({reset, stop, start} !== 3'b000) begin
        bad++;
        $display("FAIL release_no_pulse cyc=%0d got=%b want=000", cyc, {reset, stop, start});
      end
    end
    total++;
    if (ss_level !== 1'b0) begin bad++; $display("FAIL ss_level_low got=%b want=0", ss_level); end
  endtask

  task automatic test_ss_decode();
    logic [2:0] want;
    logic [1:0] st_tab [3];
    logic [2:0] ex_tab [3];
    st_tab = '{2'b01, 2'b10, 2'b11};
    ex_tab = '{3'b010, 3'b001, 3'b000};
    for (int t = 0; t < 3; t++) begin
      status     = st_tab[t];
      btn_ss_raw = 1'b1;
      if (ex_tab[t] != 3'b000) sb.push_back('{at: cyc + 8, p: ex_tab[t]});
      for (int i = 0; i < 22; i++) begin
        if (i == 12) btn_ss_raw = 1'b0;
        @(negedge clk);
        want = 3'b000;
        if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
        total++;
        if ({reset, stop, start} !== want) begin
          bad++;
          $display("FAIL ss_decode st=%b cyc=%0d got=%b want=%b", st_tab[t], cyc, {reset, stop, start}, want);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] want;
    status = 2'b10;
    for (int b = 0; b < 4; b++) begin
      btn_ss_raw = (b % 2 == 0);
      @(negedge clk);
    end
    btn_ss_raw = 1'b1;
    sb.push_back('{at: cyc + 8, p: 3'b001});
    for (int i = 0; i < 22; i++) begin
      if (i == 12) btn_ss_raw = 1'b0;
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] want;
    status      = 2'b01;
    btn_ss_raw  = 1'b1;
    btn_rst_raw = 1'b1;
    sb.push_back('{at: cyc + 8, p: 3'b100});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL simultaneous cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
    total++;
    if (rst_level !== 1'b1) begin bad++; $display("FAIL rst_level_high got=%b want=1", rst_level); end
    btn_ss_raw  = 1'b0;
    btn_rst_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({reset, stop, start} !== 3'b000) begin
        bad++;
        $display("FAIL simul_release cyc=%0d got=%b want=000", cyc, {reset, stop, start});
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [2:0] want;
    status     = 2'b00;
    btn_ss_raw = 1'b1;
    sb.push_back('{at: cyc + 8, p: 3'b001});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL pre_reset_press cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({start, stop, reset, ss_level, rst_level} !== 5'b0) begin
      bad++;
      $display("FAIL async_clear got=%b want=00000", {start, stop, reset, ss_level, rst_level});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({start, stop, reset, ss_level, rst_level} !== 5'b0) begin
        bad++;
        $display("FAIL held_in_reset cyc=%0d got=%b want=00000", cyc, {start, stop, reset, ss_level, rst_level});
      end
    end
    rst_n = 1'b1;
    sb.push_back('{at: cyc + 8, p: 3'b001});
    for (int i = 0; i < 22; i++) begin
      if (i == 12) btn_ss_raw = 1'b0;
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL post_reset_press cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
  endtask

  task automatic test_long_press();
    logic [2:0] want;
    status     = 2'b00;
    btn_ss_raw = 1'b1;
    sb.push_back('{at: cyc + 8, p: 3'b001});
`ifdef LONG_PRESS_RESET_EN
    sb.push_back('{at: cyc + 25, p: 3'b100});
`endif
    for (int i = 0; i < 52; i++) begin
      if (i == 40) btn_ss_raw = 1'b0;
      @(negedge clk);
      want = 3'b000;
      if (sb.size() > 0 && sb[0].at == cyc) begin want = sb[0].p; void'(sb.pop_front()); end
      total++;
      if ({reset, stop, start} !== want) begin
        bad++;
        $display("FAIL long_press cyc=%0d got=%b want=%b", cyc, {reset, stop, start}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_start();
    test_ss_decode();
    test_bounce();
    test_simultaneous();
    test_reset_mid_press();
    test_long_press();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0 pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
